audio_voice_scheduler: RTL and testbench

//  Per-sample scheduler for the shared codec output path. On each LRCK falling edge, polls up to
//  NUM_VOICES voice engines (Karplus-Strong strings) one at a time over a req/ack handshake,

---
 rtl/audio_sched_pkg.sv | 51 +++++
 rtl/lrck_edge_detect.sv | 33 +++
 rtl/audio_voice_scheduler.sv | 217 +++++++++++++++++++++
 tb/tb_audio_voice_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// ---------------------------------------------------------------------------
// audio_sched_pkg
// Shared types and helpers for the audio voice scheduler.
//   state_t      : scheduler FSM states (IDLE, SCAN, REQ, COMMIT)
//   calc_idx_w   : voice index width for a given voice count (minimum 1)
//   calc_acc_w   : accumulator width that can hold the sum of all voices
//   IDX_W, ACC_W : the above evaluated for the default 16-bit / 8-voice build
//   sat_to_dw    : clamp a 32-bit signed value into a dw-bit signed range
// ---------------------------------------------------------------------------
package audio_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REQ    = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_VOICES = 8;

    function automatic int calc_idx_w(input int num_voices);
        return (num_voices < 2) ? 1 : $clog2(num_voices);
    endfunction

    // One sign bit plus enough headroom for every voice at full scale,
    // so the running sum can never wrap.
    function automatic int calc_acc_w(input int data_width, input int num_voices);
        return data_width + $clog2(num_voices) + 1;
    endfunction

    localparam int IDX_W = calc_idx_w(DEF_NUM_VOICES);
    localparam int ACC_W = calc_acc_w(DEF_DATA_WIDTH, DEF_NUM_VOICES);

    // Callers truncate the result to dw bits; the clamp guarantees the
    // discarded upper bits are pure sign extension.
    function automatic logic signed [31:0] sat_to_dw(input logic signed [31:0] value,
                                                     input int                 dw);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/lrck_edge_detect.sv
// ---------------------------------------------------------------------------
// lrck_edge_detect
// Registers the codec LR clock once and produces a one-cycle pulse the cycle
// after a falling edge of iLRCK is seen. iLRCK is generated in the iCLK_18_4
// domain, so no synchronizer is needed.
// Ports:
//   iCLK_18_4 in  system clock
//   iRST      in  synchronous reset, active-high
//   iLRCK     in  codec LR clock
//   oFALL     out one-cycle pulse, registered, following an iLRCK 1->0 edge
// ---------------------------------------------------------------------------
module lrck_edge_detect (
    input  logic iCLK_18_4,
    input  logic iRST,
    input  logic iLRCK,
    output logic oFALL
);

    logic lrck_q;

    // lrck_q resets low so a line that is high out of reset is not taken
    // for a falling edge.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            lrck_q <= 1'b0;
            oFALL  <= 1'b0;
        end else begin
            lrck_q <= iLRCK;
            oFALL  <= lrck_q & ~iLRCK;
        end
    end

endmodule

// File: rtl/audio_voice_scheduler.sv
// ---------------------------------------------------------------------------
// audio_voice_scheduler
// Once per audio frame (iLRCK falling edge) polls each enabled voice engine
// in index order, sums the returned samples, scales the sum by an arithmetic
// right shift and saturates it into the L/R output words. The codec
// serializer picks the words up on the following frame edge.
//
// Optional feature, macro AUDIO_SCHED_PAN_EN:
//   defined   : adds iVOICE_PAN; each voice goes to L (pan=0) or R (pan=1),
//               and the two channels are saturated independently.
//   undefined : single mono accumulator, oAUD_L == oAUD_R.
//
// Voice handshake: oVOICE_REQ rises with oVOICE_IDX naming the voice and both
// hold steady until the first cycle iVOICE_ACK is high while oVOICE_REQ is
// high; iVOICE_SAMPLE is captured on that cycle and oVOICE_REQ drops on the
// next one. iVOICE_ACK seen while oVOICE_REQ is low is ignored. A voice that
// has not acked after TIMEOUT cycles of REQ is dropped and counts as 0.
//
// Ports:
//   iCLK_18_4      in  18.432 MHz system clock
//   iRST           in  synchronous reset, active-high
//   iLRCK          in  codec LR clock (iCLK_18_4 domain)
//   iVOICE_EN      in  per-voice enable mask, latched at frame start
//   iVOICE_PAN     in  per-voice pan, 1=right (AUDIO_SCHED_PAN_EN only)
//   oVOICE_REQ     out request to voice oVOICE_IDX
//   oVOICE_IDX     out voice being polled
//   iVOICE_ACK     in  voice sample valid
//   iVOICE_SAMPLE  in  signed voice sample
//   oAUD_L/oAUD_R  out signed mixed output words
//   oFRAME_DONE    out one-cycle pulse when oAUD_* update
//   oOVERRUN       out sticky: frame edge arrived during an active frame
//   oTIMEOUT       out sticky: at least one voice timed out
//   iCLR_STATUS    in  clears both sticky flags; a same-cycle set wins
//   oDBG_STATE     out current FSM state
//
// Worst-case frame length is NUM_VOICES*(TIMEOUT+2)+3 cycles and has to stay
// below 384 cycles (one 48 kHz frame at 18.432 MHz).
// ---------------------------------------------------------------------------
module audio_voice_scheduler
    import audio_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_VOICES = 8,
    parameter int TIMEOUT    = 32,
    parameter int MIX_SHIFT  = 3
) (
    input  logic                                  iCLK_18_4,
    input  logic                                  iRST,
    input  logic                                  iLRCK,
    input  logic [NUM_VOICES-1:0]                 iVOICE_EN,
`ifdef AUDIO_SCHED_PAN_EN
    input  logic [NUM_VOICES-1:0]                 iVOICE_PAN,
`endif
    output logic                                  oVOICE_REQ,
    output logic [calc_idx_w(NUM_VOICES)-1:0]     oVOICE_IDX,
    input  logic                                  iVOICE_ACK,
    input  logic [DATA_WIDTH-1:0]                 iVOICE_SAMPLE,
    output logic [DATA_WIDTH-1:0]                 oAUD_L,
    output logic [DATA_WIDTH-1:0]                 oAUD_R,
    output logic                                  oFRAME_DONE,
    output logic                                  oOVERRUN,
    output logic                                  oTIMEOUT,
    input  logic                                  iCLR_STATUS,
    output state_t                                oDBG_STATE
);

    localparam int SUM_W = calc_acc_w(DATA_WIDTH, NUM_VOICES);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic                    lrck_fall;
    state_t                  state;
    logic [NUM_VOICES-1:0]   pending;
    logic [CNT_W-1:0]        tcnt;
    logic signed [SUM_W-1:0] acc_l;
    logic signed [SUM_W-1:0] sample_ext;
    logic signed [31:0]      wide_l;
    logic [DATA_WIDTH-1:0]   mix_l;
`ifdef AUDIO_SCHED_PAN_EN
    logic [NUM_VOICES-1:0]   pan_lat;
    logic signed [SUM_W-1:0] acc_r;
    logic signed [31:0]      wide_r;
    logic [DATA_WIDTH-1:0]   mix_r;
`endif

    lrck_edge_detect u_lrck_edge (
        .iCLK_18_4 (iCLK_18_4),
        .iRST      (iRST),
        .iLRCK     (iLRCK),
        .oFALL     (lrck_fall)
    );

    assign oDBG_STATE = state;
    assign sample_ext = {{(SUM_W - DATA_WIDTH){iVOICE_SAMPLE[DATA_WIDTH-1]}}, iVOICE_SAMPLE};

    // Scale then clamp. The accumulator is sign-extended to 32 bits first so
    // the package helper can be shared by every width configuration.
    always_comb begin
        wide_l = {{(32 - SUM_W){acc_l[SUM_W-1]}}, acc_l};
        mix_l  = DATA_WIDTH'(sat_to_dw(wide_l >>> MIX_SHIFT, DATA_WIDTH));
`ifdef AUDIO_SCHED_PAN_EN
        wide_r = {{(32 - SUM_W){acc_r[SUM_W-1]}}, acc_r};
        mix_r  = DATA_WIDTH'(sat_to_dw(wide_r >>> MIX_SHIFT, DATA_WIDTH));
`endif
    end

    // pending holds the voices still to be polled this frame. Served voices
    // clear their bit, so SCAN can commit as soon as pending is empty instead
    // of walking the remaining disabled indices.
    always_ff @(posedge iCLK_18_4) begin
        if (iRST) begin
            state       <= IDLE;
            pending     <= '0;
            tcnt        <= '0;
            acc_l       <= '0;
`ifdef AUDIO_SCHED_PAN_EN
            pan_lat     <= '0;
            acc_r       <= '0;
`endif
            oVOICE_REQ  <= 1'b0;
            oVOICE_IDX  <= '0;
            oAUD_L      <= '0;
            oAUD_R      <= '0;
            oFRAME_DONE <= 1'b0;
            oOVERRUN    <= 1'b0;
            oTIMEOUT    <= 1'b0;
        end else begin
            oFRAME_DONE <= 1'b0;

            // Clear first; any set further down in this block overrides it.
            if (iCLR_STATUS) begin
                oOVERRUN <= 1'b0;
                oTIMEOUT <= 1'b0;
            end

            if (lrck_fall) begin
                // A new frame always restarts the scan. If the previous frame
                // was still running its partial sum is thrown away and the
                // output words keep the last committed mix.
                if (state != IDLE) begin
                    oOVERRUN <= 1'b1;
                end
                oVOICE_REQ <= 1'b0;
                oVOICE_IDX <= '0;
                pending    <= iVOICE_EN;
                tcnt       <= '0;
                acc_l      <= '0;
`ifdef AUDIO_SCHED_PAN_EN
                pan_lat    <= iVOICE_PAN;
                acc_r      <= '0;
`endif
                state      <= SCAN;
            end else begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end

                    SCAN: begin
                        if (pending == '0) begin
                            state <= COMMIT;
                        end else if (pending[oVOICE_IDX]) begin
                            oVOICE_REQ <= 1'b1;
                            tcnt       <= '0;
                            state      <= REQ;
                        end else begin
                            oVOICE_IDX <= oVOICE_IDX + 1'b1;
                        end
                    end

                    REQ: begin
                        if (iVOICE_ACK) begin
`ifdef AUDIO_SCHED_PAN_EN
                            if (pan_lat[oVOICE_IDX]) begin
                                acc_r <= acc_r + sample_ext;
                            end else begin
                                acc_l <= acc_l + sample_ext;
                            end
`else
                            acc_l <= acc_l + sample_ext;
`endif
                            oVOICE_REQ          <= 1'b0;
                            pending[oVOICE_IDX] <= 1'b0;
                            oVOICE_IDX          <= oVOICE_IDX + 1'b1;
                            state               <= SCAN;
                        end else if (tcnt == CNT_LAST) begin
                            // REQ has now been high for TIMEOUT cycles.
                            oVOICE_REQ          <= 1'b0;
                            oTIMEOUT            <= 1'b1;
                            pending[oVOICE_IDX] <= 1'b0;
                            oVOICE_IDX          <= oVOICE_IDX + 1'b1;
                            state               <= SCAN;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end

                    COMMIT: begin
                        oAUD_L      <= mix_l;
`ifdef AUDIO_SCHED_PAN_EN
                        oAUD_R      <= mix_r;
`else
                        oAUD_R      <= mix_l;
`endif
                        oFRAME_DONE <= 1'b1;
                        state       <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_voice_scheduler
// Bench for audio_voice_scheduler. Voice engines are emulated by per-voice
// ack delay / sample tables; the expected mix, poll order, REQ lengths and
// timeout flag come from a frame-level model built from the voice tables.
// ---------------------------------------------------------------------------
module tb_audio_voice_scheduler;
    import audio_sched_pkg::*;

    localparam int DW    = 16;
    localparam int NV    = 8;
    localparam int IW    = 3;
    localparam int TO    = 8;
    localparam int SH    = 1;
    localparam int NEVER = 1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #27 clk = ~clk;

    logic            lrck;
    logic [NV-1:0]   en;
    logic [NV-1:0]   pan;
    logic            req;
    logic [IW-1:0]   idx;
    logic            ack;
    logic [DW-1:0]   sample;
    logic [DW-1:0]   aud_l;
    logic [DW-1:0]   aud_r;
    logic            done;
    logic            ovr;
    logic            tmo;
    logic            clr;
    state_t          dbg;

    audio_voice_scheduler #(
        .DATA_WIDTH (DW),
        .NUM_VOICES (NV),
        .TIMEOUT    (TO),
        .MIX_SHIFT  (SH)
    ) dut (
        .iCLK_18_4     (clk),
        .iRST          (rst),
        .iLRCK         (lrck),
        .iVOICE_EN     (en),
`ifdef AUDIO_SCHED_PAN_EN
        .iVOICE_PAN    (pan),
`endif
        .oVOICE_REQ    (req),
        .oVOICE_IDX    (idx),
        .iVOICE_ACK    (ack),
        .iVOICE_SAMPLE (sample),
        .oAUD_L        (aud_l),
        .oAUD_R        (aud_r),
        .oFRAME_DONE   (done),
        .oOVERRUN      (ovr),
        .oTIMEOUT      (tmo),
        .iCLR_STATUS   (clr),
        .oDBG_STATE    (dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- voice emulation + scoreboard ----------------
    int            v_delay [NV];   // REQ cycles before ack (0 = ack in first REQ cycle)
    int            v_samp  [NV];
    bit            spurious;
    bit            len_chk;
    logic [IW-1:0] exp_q[$];       // expected poll order
    int            exp_len_q[$];   // expected REQ-high length per poll
    logic [IW-1:0] cur_idx;
    logic          prev_req;
    int            req_len;
    int            done_cnt;
    bit            tmo_seen;

    always begin
        @(posedge clk);
        #3;
        if (rst) begin
            prev_req = 1'b0;
            req_len  = 0;
            ack      = 1'b0;
        end else begin
            if (req && !prev_req) begin
                req_len = 0;
                cur_idx = idx;
                check("req_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("req_idx", idx, exp_q.pop_front());
            end
            if (req) begin
                req_len++;
                check("idx_stable", idx, cur_idx);
            end
            if (!req && prev_req && len_chk && exp_len_q.size() != 0)
                check("req_len", req_len, exp_len_q.pop_front());
            if (req && v_delay[int'(idx)] == req_len - 1) begin
                ack    = 1'b1;
                sample = v_samp[int'(idx)][DW-1:0];
            end else if (!req && spurious) begin
                ack    = 1'b1;
                sample = DW'($urandom);
            end else begin
                ack    = 1'b0;
                sample = DW'($urandom);
            end
            if (done) done_cnt++;
            if (tmo) tmo_seen = 1'b1;
            prev_req = req;
        end
    end

    // ---------------- reference model ----------------
    int exp_l, exp_r;
    bit exp_t;

    function automatic int sat_dw(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic expect_frame(input logic [NV-1:0] mask, input logic [NV-1:0] pmask);
        int sl, sr, c;
        sl = 0; sr = 0; exp_t = 0;
        for (int v = 0; v < NV; v++) begin
            if (mask[v]) begin
                exp_q.push_back(IW'(v));
                if (v_delay[v] < TO) begin
                    exp_len_q.push_back(v_delay[v] + 1);
                    c = v_samp[v];
                end else begin
                    exp_len_q.push_back(TO);
                    exp_t = 1;
                    c = 0;
                end
`ifdef AUDIO_SCHED_PAN_EN
                if (pmask[v]) sr += c; else sl += c;
`else
                sl += c;
`endif
            end
        end
`ifdef AUDIO_SCHED_PAN_EN
        exp_l = sat_dw(sl >>> SH);
        exp_r = sat_dw(sr >>> SH);
`else
        exp_l = sat_dw(sl >>> SH);
        exp_r = exp_l;
        if (pmask != pmask) exp_r = 0;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fall_edge();
        lrck = 1'b1;
        tick(1);
        lrck = 1'b0;
    endtask

    task automatic clear_status();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic start_frame(input logic [NV-1:0] mask, input logic [NV-1:0] pmask);
        en  = mask;
        pan = pmask;
        expect_frame(mask, pmask);
        done_cnt = 0;
        fall_edge();
    endtask

    task automatic finish_frame(input string tag, input bit exp_ovr, input bit chk_tmo);
        int n;
        n = 0;
        while (!done && n < 600) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        tick(3);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_aud_l"}, $signed(aud_l), exp_l);
        check({tag, "_aud_r"}, $signed(aud_r), exp_r);
        check({tag, "_ovr"}, ovr, exp_ovr);
        if (chk_tmo) check({tag, "_tmo"}, tmo, exp_t);
        check({tag, "_polls_left"}, exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag, input logic [NV-1:0] mask,
                             input logic [NV-1:0] pmask);
        clear_status();
        start_frame(mask, pmask);
        finish_frame(tag, 1'b0, 1'b1);
    endtask

    task automatic set_all(input int dly, input int smp);
        for (int v = 0; v < NV; v++) begin
            v_delay[v] = dly;
            v_samp[v]  = smp;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(54 * 60000);
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, prev_l, prev_r;
        rst = 1'b1; lrck = 1'b0; en = '0; pan = '0; clr = 1'b0;
        ack = 1'b0; sample = '0; spurious = 1'b0; len_chk = 1'b1;
        done_cnt = 0; tmo_seen = 1'b0;
        set_all(0, 0);
        tick(4);
        check("rst_req", req, 1'b0);
        check("rst_idx", idx, 0);
        check("rst_aud_l", aud_l, 0);
        check("rst_aud_r", aud_r, 0);
        check("rst_done", done, 1'b0);
        check("rst_ovr", ovr, 1'b0);
        check("rst_tmo", tmo, 1'b0);
        check("rst_state", dbg, IDLE);
        rst = 1'b0;
        tick(3);

        // four voices, ack after 3 cycles, 1000 each
        set_all(3, 1000);
        run_frame("four", 8'h0F, 8'h00);

        // full-scale positive and negative sums must clamp, not wrap
        set_all(0, 32767);
        run_frame("sat_pos", 8'hFF, 8'h00);
        set_all(1, -32768);
        run_frame("sat_neg", 8'hFF, 8'h00);

        // voice 2 never acks
        set_all(2, 1200);
        v_samp[5] = -700;
        v_delay[2] = NEVER;
        run_frame("tmo", 8'hFF, 8'h00);
        clear_status();
        check("tmo_cleared", tmo, 1'b0);

        // set wins over a clear held high for the whole frame
        clr = 1'b1;
        tmo_seen = 1'b0;
        start_frame(8'h04, 8'h00);
        tick(TO + 12);
        clr = 1'b0;
        check("tmo_set_wins", tmo_seen, 1'b1);
        check("tmo_set_wins_done", done_cnt, 1);
        exp_q.delete();
        exp_len_q.delete();

        // overrun while voice 5 is being polled
        clear_status();
        set_all(1, 300);
        v_samp[6] = -50;
        v_delay[5] = NEVER;
        run_frame("pre_ovr", 8'hFF, 8'h00);
        prev_l = int'($signed(aud_l));
        prev_r = int'($signed(aud_r));
        len_chk = 1'b0;
        for (int v = 0; v <= 5; v++) exp_q.push_back(IW'(v));
        for (int v = 0; v < NV; v++) v_samp[v] = 111 * (v + 1);
        en = 8'hFF;
        expect_frame(8'hFF, 8'h00);
        done_cnt = 0;
        fall_edge();
        n = 0;
        while (!(req && idx == 3'd5) && n < 200) begin
            tick(1);
            n++;
        end
        check("ovr_reached_v5", int'(req && idx == 3'd5), 1);
        check("ovr_before", ovr, 1'b0);
        fall_edge();
        tick(3);
        check("ovr_set", ovr, 1'b1);
        check("ovr_hold_l", $signed(aud_l), prev_l);
        check("ovr_hold_r", $signed(aud_r), prev_r);
        check("ovr_no_done", done_cnt, 0);
        finish_frame("ovr", 1'b1, 1'b1);
        exp_len_q.delete();
        len_chk = 1'b1;

        // spurious acks while idle change nothing
        prev_l = int'($signed(aud_l));
        done_cnt = 0;
        spurious = 1'b1;
        tick(12);
        check("idle_ack_done", done_cnt, 0);
        check("idle_ack_aud", $signed(aud_l), prev_l);
        check("idle_ack_state", dbg, IDLE);

        // empty mask: quick commit of 0, acks still ignored
        clear_status();
        start_frame(8'h00, 8'h00);
        n = 0;
        while (!done && n < 10) begin
            tick(1);
            n++;
        end
        check("empty_latency_ok", int'(n <= 4), 1);
        finish_frame("empty", 1'b0, 1'b1);
        spurious = 1'b0;

`ifdef AUDIO_SCHED_PAN_EN
        set_all(2, 500);
        run_frame("pan_lr", 8'h03, 8'h02);
        run_frame("pan_ll", 8'h03, 8'h00);
`endif

        // randomized frames
        for (int f = 0; f < 16; f++) begin
            for (int v = 0; v < NV; v++) begin
                v_delay[v] = int'($urandom_range(0, TO + 1));
                if ($urandom_range(0, 3) == 0)
                    v_samp[v] = int'($urandom_range(0, 65535)) - 32768;
                else
                    v_samp[v] = int'($urandom_range(0, 8000)) - 4000;
            end
            run_frame("rand", NV'($urandom_range(0, 255)), NV'($urandom_range(0, 255)));
        end

        // reset in the middle of a poll
        set_all(NEVER, 0);
        len_chk = 1'b0;
        exp_q.push_back('0);
        en = 8'h01;
        fall_edge();
        n = 0;
        while (!req && n < 20) begin
            tick(1);
            n++;
        end
        check("mid_rst_req_seen", req, 1'b1);
        rst = 1'b1;
        tick(1);
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_state", dbg, IDLE);
        check("mid_rst_aud", aud_l, 0);
        check("mid_rst_tmo", tmo, 1'b0);
        rst = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
